// File: rtl/cy1373_pkg.sv
// Shared types and helpers for the CY7C1373-class flow-through NoBL SRAM model.
package cy1373_pkg;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 18;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_e;

  // Low two address bits of a burst beat; upper bits come straight from the base.
  function automatic logic [1:0] burst_addr(input logic [1:0] base,
                                            input logic [1:0] count,
                                            input logic       mode);
    return mode ? (base ^ count) : (base + count);
  endfunction

endpackage

// File: rtl/cy1373_burst_ctr.sv
// Command decode and burst sequencer: base latch, 2-bit count, byte enables and the
// op of the access registered at the last enabled edge.
module cy1373_burst_ctr
  import cy1373_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              sel_i,
  input  logic              adv_lb_i,
  input  logic              bweb_i,
  input  logic [1:0]        bwb_i,
  input  logic [ADDR_W-1:0] a_i,
  input  logic              mode_i,
  output logic [ADDR_W-1:0] addr_o,
  output op_e               op_o,
  output logic [1:0]        bw_o
);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              act_q, act_d;
  op_e               op_q, op_d;
  logic [1:0]        bw_q, bw_d;

  always_comb begin
    base_d = base_q;
    cnt_d  = cnt_q;
    act_d  = act_q;
    op_d   = op_q;
    bw_d   = bw_q;
    if (!adv_lb_i) begin
      if (sel_i) begin
        base_d = a_i;
        cnt_d  = 2'd0;
        act_d  = 1'b1;
        op_d   = bweb_i ? OP_READ : OP_WRITE;
        bw_d   = bwb_i;
      end else begin
        act_d = 1'b0;
        op_d  = OP_IDLE;
      end
    end else if (act_q) begin
      // Advance repeats the latched op and byte enables at the next beat.
      cnt_d = cnt_q + 2'd1;
    end else begin
      op_d = OP_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q <= '0;
      cnt_q  <= 2'd0;
      act_q  <= 1'b0;
      op_q   <= OP_IDLE;
      bw_q   <= 2'b11;
    end else if (en_i) begin
      base_q <= base_d;
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      op_q   <= op_d;
      bw_q   <= bw_d;
    end
  end

  assign addr_o = {base_q[ADDR_W-1:2], burst_addr(base_q[1:0], cnt_q, mode_i)};
  assign op_o   = op_q;
  assign bw_o   = bw_q;

endmodule

// File: rtl/cy1373_sram.sv
// Flow-through NoBL x18 SRAM: reads drive d in the cycle after the address edge,
// writes take d one enabled edge after their address.
module cy1373_sram
  import cy1373_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  inout  wire [DATA_W-1:0]  d,
  input  logic [ADDR_W-1:0] a,
  input  logic [1:0]        bwb,
  input  logic              bweb,
  input  logic              adv_lb,
  input  logic              ce1b,
  input  logic              ce2,
  input  logic              ce3b,
  input  logic              oeb,
  input  logic              cenb,
  input  logic              mode
);

  localparam int BYTE_W = DATA_W / 2;

  logic [DATA_W-1:0] mem [0:2**ADDR_W-1];

  logic [ADDR_W-1:0] acc_addr;
  op_e               acc_op;
  logic [1:0]        acc_bw;
  logic              sel;
  logic              rd_drive;

  assign sel = !ce1b && ce2 && !ce3b;

  cy1373_burst_ctr #(.ADDR_W(ADDR_W)) u_ctr (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (!cenb),
    .sel_i    (sel),
    .adv_lb_i (adv_lb),
    .bweb_i   (bweb),
    .bwb_i    (bwb),
    .a_i      (a),
    .mode_i   (mode),
    .addr_o   (acc_addr),
    .op_o     (acc_op),
    .bw_o     (acc_bw)
  );

  // Pending write commits at the next enabled edge, ahead of any read issued there.
  always_ff @(posedge clk) begin
    if (rst_n && !cenb && acc_op == OP_WRITE) begin
      for (int b = 0; b < 2; b++) begin
        if (!acc_bw[b]) begin
          mem[acc_addr][b*BYTE_W +: BYTE_W] <= d[b*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  assign rd_drive = (acc_op == OP_READ) && !oeb;
  assign d        = rd_drive ? mem[acc_addr] : {DATA_W{1'bz}};

endmodule

// File: tb/tb_cy1373_sram.sv
// Directed bench for cy1373_sram; bus release is probed by driving zero and reading it back.
module tb_cy1373_sram;

  logic        clk;
  logic        rst_n;
  wire  [17:0] d;
  logic [19:0] a;
  logic [1:0]  bwb;
  logic        bweb, adv_lb, ce1b, ce2, ce3b, oeb, cenb, mode;
  logic [17:0] d_drv;
  logic        d_oe;
  int          n_cmp = 0;
  int          n_err = 0;

  assign d = d_oe ? d_drv : 18'bz;

  cy1373_sram dut (
    .clk(clk), .rst_n(rst_n), .d(d), .a(a), .bwb(bwb), .bweb(bweb),
    .adv_lb(adv_lb), .ce1b(ce1b), .ce2(ce2), .ce3b(ce3b), .oeb(oeb),
    .cenb(cenb), .mode(mode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A released bus reads back exactly what the bench drives.
  task automatic chk_z(input string tag);
    d_drv = 18'h0;
    d_oe  = 1'b1;
    #1;
    chk(tag, d, 18'h0);
    d_oe  = 1'b0;
    #1;
  endtask

  task automatic set_cmd(input logic adv, input logic s, input logic we_n,
                         input logic [1:0] bw, input logic [19:0] addr);
    adv_lb = adv; ce1b = 1'b0; ce2 = s; ce3b = 1'b0;
    bweb = we_n; bwb = bw; a = addr;
  endtask

  task automatic desel();
    set_cmd(1'b0, 1'b0, 1'b1, 2'b11, 20'h0);
  endtask

  task automatic advance();
    set_cmd(1'b1, 1'b1, 1'b1, 2'b11, 20'h0);
  endtask

  task automatic wr1(input logic [19:0] addr, input logic [17:0] data, input logic [1:0] bw);
    set_cmd(1'b0, 1'b1, 1'b0, bw, addr);
    tick();
    d_drv = data;
    d_oe  = 1'b1;
    desel();
    tick();
    d_oe  = 1'b0;
  endtask

  task automatic rd1(input logic [19:0] addr, input logic [17:0] exp, input string tag);
    set_cmd(1'b0, 1'b1, 1'b1, 2'b11, addr);
    tick();
    chk(tag, d, exp);
    desel();
    tick();
  endtask

  initial begin
    rst_n = 1'b0; cenb = 1'b0; oeb = 1'b0; mode = 1'b0;
    d_oe = 1'b0; d_drv = 18'h0;
    desel();
    tick();
    tick();
    chk_z("reset_z");
    rst_n = 1'b1;

    wr1(20'h00010, 18'h12345, 2'b00);
    rd1(20'h00010, 18'h12345, "wr_rd");

    wr1(20'h00020, 18'h3FFFF, 2'b00);
    wr1(20'h00020, 18'h00000, 2'b10);
    rd1(20'h00020, 18'h3FE00, "bw10");
    wr1(20'h00021, 18'h3FFFF, 2'b00);
    wr1(20'h00021, 18'h00000, 2'b01);
    rd1(20'h00021, 18'h001FF, "bw01");
    wr1(20'h00021, 18'h00000, 2'b11);
    rd1(20'h00021, 18'h001FF, "bw11");

    for (int i = 0; i < 4; i++) wr1(20'(20'h40 + i), 18'(18'h100 + i), 2'b00);

    // Linear burst from low bits 2: 2,3,0,1
    set_cmd(1'b0, 1'b1, 1'b1, 2'b11, 20'h00042);
    tick(); chk("lin0", d, 18'h102);
    advance();
    tick(); chk("lin1", d, 18'h103);
    tick(); chk("lin2", d, 18'h100);
    tick(); chk("lin3", d, 18'h101);
    desel();
    tick(); chk_z("burst_end_z");

    // Interleaved burst from low bits 1: 1,0,3,2
    mode = 1'b1;
    set_cmd(1'b0, 1'b1, 1'b1, 2'b11, 20'h00041);
    tick(); chk("ilv0", d, 18'h101);
    advance();
    tick(); chk("ilv1", d, 18'h100);
    tick(); chk("ilv2", d, 18'h103);
    tick(); chk("ilv3", d, 18'h102);
    desel();
    tick();
    mode = 1'b0;

    // Stall mid-burst holds the beat for an extra cycle
    set_cmd(1'b0, 1'b1, 1'b1, 2'b11, 20'h00040);
    tick(); chk("stall0", d, 18'h100);
    advance(); cenb = 1'b1;
    tick(); chk("stall_hold", d, 18'h100);
    cenb = 1'b0;
    tick(); chk("stall_next", d, 18'h101);
    desel();
    tick();

    set_cmd(1'b0, 1'b0, 1'b1, 2'b11, 20'h00010);
    tick(); chk_z("ce2_desel");

    oeb = 1'b1;
    set_cmd(1'b0, 1'b1, 1'b1, 2'b11, 20'h00010);
    tick(); chk_z("oeb_hi");
    oeb = 1'b0;
    #1; chk("oeb_lo", d, 18'h12345);
    desel();
    tick();

    // Write then read of the same address on the next edge
    set_cmd(1'b0, 1'b1, 1'b0, 2'b00, 20'h00005);
    tick();
    d_drv = 18'h0AAAA; d_oe = 1'b1;
    set_cmd(1'b0, 1'b1, 1'b1, 2'b11, 20'h00005);
    tick();
    d_oe = 1'b0;
    #1; chk("wr_rd_b2b", d, 18'h0AAAA);
    desel();
    tick();

    // Read then immediate write: RAM must let go of the bus
    set_cmd(1'b0, 1'b1, 1'b1, 2'b11, 20'h00010);
    tick(); chk("rd_before_wr", d, 18'h12345);
    set_cmd(1'b0, 1'b1, 1'b0, 2'b00, 20'h00006);
    tick(); chk_z("rd_wr_release");
    d_drv = 18'h15555; d_oe = 1'b1;
    #1; chk("rd_wr_nocont", d, 18'h15555);
    desel();
    tick();
    d_oe = 1'b0;
    rd1(20'h00006, 18'h15555, "rd_wr_data");

    // Pending write survives a stall and commits at the next enabled edge
    set_cmd(1'b0, 1'b1, 1'b0, 2'b00, 20'h00007);
    tick();
    cenb = 1'b1; d_drv = 18'h11111; d_oe = 1'b1;
    tick();
    cenb = 1'b0; d_drv = 18'h0BEEF;
    desel();
    tick();
    d_oe = 1'b0;
    rd1(20'h00007, 18'h0BEEF, "wr_stall");

    // Reset mid-burst, asserted together with a stall
    set_cmd(1'b0, 1'b1, 1'b1, 2'b11, 20'h00040);
    tick(); chk("rst_b0", d, 18'h100);
    advance();
    tick(); chk("rst_b1", d, 18'h101);
    rst_n = 1'b0; cenb = 1'b1;
    tick();
    rst_n = 1'b1; cenb = 1'b0;
    chk_z("rst_z");
    tick(); chk_z("rst_adv_desel");
    desel();
    tick();
    rd1(20'h00040, 18'h100, "rst_keep");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
